// File: rtl/demux_stream_router.sv
`default_nettype none
// ============================================================================
// Module   : demux_stream_router
// Brief    : Packet-atomic 1-to-N valid/ready stream demultiplexer. Locks the
//            destination on the first beat of each packet and steers every
//            beat through a one-entry output register to that channel.
//            Optional macro DEMUX_PKTCNT_EN enables per-channel 16-bit
//            completed-packet counters on pkt_cnt (tied to zero otherwise).
// Revision : 1.0 - initial release
// ============================================================================
module demux_stream_router #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4,
  localparam int SEL_W = $clog2(N_OUT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_last,
  input  logic [SEL_W-1:0]    in_dest,
  output logic [N_OUT-1:0]    out_valid,
  input  logic [N_OUT-1:0]    out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_last,
  output logic                busy,
  output logic [SEL_W-1:0]    cur_dest,
  output logic [16*N_OUT-1:0] pkt_cnt
);

  localparam logic [N_OUT-1:0] c_onehot_base = {{(N_OUT-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_PKT  = 1'b1
  } state_t;

  state_t              r_state;
  logic [SEL_W-1:0]    r_cur_dest;
  logic [SEL_W-1:0]    r_dest;
  logic [DATA_W-1:0]   r_data;
  logic                r_last;
  logic                r_full;

  logic                w_leave;
  logic                w_accept;
  logic [SEL_W-1:0]    w_eff_dest;

  // The register carries its own destination, so only that channel's ready
  // can drain it; a draining register can accept a new beat in the same cycle.
  assign w_leave    = r_full & out_ready[r_dest];
  assign in_ready   = ~r_full | out_ready[r_dest];
  assign w_accept   = in_valid & in_ready;
  assign w_eff_dest = (r_state == S_IDLE) ? in_dest : r_cur_dest;

  // Packet framing: lock destination on the first beat, release on last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cur_dest <= '0;
    end else if (w_accept) begin
      if (r_state == S_IDLE) begin
        r_cur_dest <= in_dest;
        r_state    <= in_last ? S_IDLE : S_PKT;
      end else if (in_last) begin
        r_state    <= S_IDLE;
      end
    end
  end

  // One-entry output register; data/last stay stale once drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_data <= '0;
      r_last <= 1'b0;
      r_dest <= '0;
    end else if (w_accept) begin
      r_full <= 1'b1;
      r_data <= in_data;
      r_last <= in_last;
      r_dest <= w_eff_dest;
    end else if (w_leave) begin
      r_full <= 1'b0;
    end
  end

  assign out_valid = r_full ? (c_onehot_base << r_dest) : '0;
  assign out_data  = r_data;
  assign out_last  = r_last;
  assign busy      = (r_state == S_PKT);
  assign cur_dest  = r_cur_dest;

`ifdef DEMUX_PKTCNT_EN
  generate
    for (genvar d = 0; d < N_OUT; d++) begin : g_pkt_cnt
      logic [15:0] r_cnt;

      // Count packets as their last beat leaves toward channel d; wraps freely.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (w_leave && r_last && (r_dest == SEL_W'(d))) begin
          r_cnt <= r_cnt + 16'd1;
        end
      end

      assign pkt_cnt[16*d +: 16] = r_cnt;
    end
  endgenerate
`else
  assign pkt_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux_stream_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_stream_router
// Brief    : Self-checking bench for demux_stream_router (N_OUT=4, DATA_W=8)
//            using a queue-based reference model, directed scenarios and
//            randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_stream_router;

  localparam int DATA_W = 8;
  localparam int N_OUT  = 4;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic [1:0]        in_dest;
  logic [N_OUT-1:0]  out_valid;
  logic [N_OUT-1:0]  out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic [1:0]        cur_dest;
  logic [63:0]       pkt_cnt;

  demux_stream_router #(.DATA_W(DATA_W), .N_OUT(N_OUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .cur_dest(cur_dest), .pkt_cnt(pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] dest;
    logic [7:0] data;
    logic       last;
  } beat_t;

  // Reference model state: beats waiting to leave, packet framing, counters.
  beat_t       m_q[$];
  logic        m_open;
  logic [1:0]  m_cur;
  logic [7:0]  m_data;
  logic        m_last;
  logic [15:0] m_cnt [N_OUT];

  int vectors;
  int miscompares;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  function automatic logic [63:0] exp_cnt();
    logic [63:0] v;
    v = '0;
`ifdef DEMUX_PKTCNT_EN
    for (int d = 0; d < N_OUT; d++) v[16*d +: 16] = m_cnt[d];
`endif
    return v;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_open = 1'b0;
    m_cur  = '0;
    m_data = '0;
    m_last = 1'b0;
    for (int d = 0; d < N_OUT; d++) m_cnt[d] = '0;
  endtask

  // Compare every output against the model (called away from the clock edge).
  task automatic check_all(input logic full_check);
    logic [3:0] ev;
    logic       er;
    ev = (m_q.size() != 0) ? (4'b0001 << m_q[0].dest) : 4'b0000;
    er = (m_q.size() == 0) || out_ready[m_q[0].dest];
    chk("in_ready", {63'd0, in_ready}, {63'd0, er});
    if (full_check) begin
      chk("out_valid", {60'd0, out_valid}, {60'd0, ev});
      chk("out_data", {56'd0, out_data}, {56'd0, m_data});
      chk("out_last", {63'd0, out_last}, {63'd0, m_last});
      chk("busy", {63'd0, busy}, {63'd0, m_open});
      chk("cur_dest", {62'd0, cur_dest}, {62'd0, m_cur});
      chk("pkt_cnt", pkt_cnt, exp_cnt());
    end
  endtask

  // One clock cycle: drive after the falling edge, check, advance the model
  // with the handshakes that occur at the rising edge, return at falling edge.
  task automatic step(input logic v, input logic [7:0] d, input logic l,
                      input logic [1:0] ds, input logic [3:0] rdy,
                      input logic full_check);
    logic  er, leave, acc;
    beat_t b;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    in_dest   = ds;
    out_ready = rdy;
    #1;
    check_all(full_check);
    er    = (m_q.size() == 0) || rdy[m_q[0].dest];
    leave = (m_q.size() != 0) && rdy[m_q[0].dest];
    acc   = v && er;
    @(posedge clk);
    if (leave) begin
      if (m_q[0].last) m_cnt[m_q[0].dest] = m_cnt[m_q[0].dest] + 16'd1;
      void'(m_q.pop_front());
    end
    if (acc) begin
      b.dest = m_open ? m_cur : ds;
      b.data = d;
      b.last = l;
      m_cur  = b.dest;
      m_data = d;
      m_last = l;
      m_open = !l;
      m_q.push_back(b);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_last     = 1'b0;
    in_dest     = '0;
    out_ready   = '0;
    rst_n       = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);

    // Reset values
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {60'd0, out_valid}, 64'd0);
    chk("rst_out_data", {56'd0, out_data}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_pkt_cnt", pkt_cnt, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single 3-beat packet to channel 2; later in_dest values must be ignored
    step(1'b1, 8'h11, 1'b0, 2'd2, 4'hF, 1'b1);
    chk("pkt_b0_valid", {60'd0, out_valid}, 64'h4);
    chk("pkt_b0_busy", {63'd0, busy}, 64'd1);
    step(1'b1, 8'h22, 1'b0, 2'd0, 4'hF, 1'b1);
    chk("pkt_b1_valid", {60'd0, out_valid}, 64'h4);
    chk("pkt_b1_data", {56'd0, out_data}, 64'h22);
    chk("pkt_b1_busy", {63'd0, busy}, 64'd1);
    step(1'b1, 8'h33, 1'b1, 2'd0, 4'hF, 1'b1);
    chk("pkt_b2_valid", {60'd0, out_valid}, 64'h4);
    chk("pkt_b2_data", {56'd0, out_data}, 64'h33);
    chk("pkt_b2_busy", {63'd0, busy}, 64'd0);
    step(1'b0, 8'h00, 1'b0, 2'd0, 4'hF, 1'b1);

    // Stall on channel 1 for five cycles, then release
    step(1'b1, 8'hA5, 1'b1, 2'd1, 4'b1101, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'h5A, 1'b1, 2'd2, 4'b1101, 1'b1);
      chk("stall_valid", {60'd0, out_valid}, 64'h2);
      chk("stall_data", {56'd0, out_data}, 64'hA5);
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
    end
    step(1'b1, 8'h5A, 1'b1, 2'd2, 4'hF, 1'b1);
    chk("release_valid", {60'd0, out_valid}, 64'h4);
    chk("release_data", {56'd0, out_data}, 64'h5A);
    step(1'b0, 8'h00, 1'b0, 2'd0, 4'hF, 1'b1);

    // Back-to-back single-beat packets to different channels
    step(1'b1, 8'h01, 1'b1, 2'd3, 4'hF, 1'b1);
    chk("b2b_first", {60'd0, out_valid}, 64'h8);
    step(1'b1, 8'h02, 1'b1, 2'd0, 4'hF, 1'b1);
    chk("b2b_second", {60'd0, out_valid}, 64'h1);
    chk("b2b_data", {56'd0, out_data}, 64'h02);
    step(1'b0, 8'h00, 1'b0, 2'd0, 4'hF, 1'b1);

    // Ready on the wrong channel must not drain the beat
    step(1'b1, 8'h77, 1'b1, 2'd0, 4'hF, 1'b1);
    step(1'b1, 8'h78, 1'b1, 2'd1, 4'b1000, 1'b1);
    chk("wrong_ch_valid", {60'd0, out_valid}, 64'h1);
    chk("wrong_ch_in_ready", {63'd0, in_ready}, 64'd0);
    step(1'b0, 8'h00, 1'b0, 2'd0, 4'hF, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0),
           2'($urandom), ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom), 1'b1);
    end

    // Asynchronous reset mid-packet with the register held full
    step(1'b1, 8'hC3, 1'b0, 2'd3, 4'h0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 2'd0, 4'h0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {60'd0, out_valid}, 64'd0);
    chk("arst_out_data", {56'd0, out_data}, 64'd0);
    chk("arst_out_last", {63'd0, out_last}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_cur_dest", {62'd0, cur_dest}, 64'd0);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("arst_pkt_cnt", pkt_cnt, 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", {63'd0, busy}, 64'd0);
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Packet counting: 5 packets to channel 1, 2 multi-beat packets to channel 3
    for (int i = 0; i < 5; i++) step(1'b1, 8'(i), 1'b1, 2'd1, 4'hF, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 8'hE0, 1'b0, 2'd3, 4'hF, 1'b1);
      step(1'b1, 8'hE1, 1'b1, 2'd0, 4'hF, 1'b1);
    end
    step(1'b0, 8'h00, 1'b0, 2'd0, 4'hF, 1'b1);
`ifdef DEMUX_PKTCNT_EN
    chk("cnt_totals", pkt_cnt, 64'h0002_0000_0005_0000);
    // 65536 more single-beat packets to channel 0 wrap its counter to zero
    step(1'b1, 8'h00, 1'b1, 2'd0, 4'hF, 1'b1);
    for (int i = 1; i < 65536; i++) step(1'b1, 8'(i), 1'b1, 2'd0, 4'hF, 1'b0);
    step(1'b0, 8'h00, 1'b0, 2'd0, 4'hF, 1'b1);
    chk("cnt_wrap", pkt_cnt, 64'h0002_0000_0005_0000);
`else
    chk("cnt_absent", pkt_cnt, 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/demux_stream_router.md
# demux_stream_router

Packet-level controller for a 1-to-N stream demultiplexer. Accepts a valid/ready input stream, locks a destination at the first beat of each packet, and steers every beat of that packet through a one-entry output register to the selected output channel until the beat marked last. It sits between a single upstream producer and N downstream consumers, replacing the purely combinational select of the 1-to-2 demux with handshaked, packet-atomic routing.

## Interface
Parameters:
- DATA_W, 8, payload width in bits
- N_OUT, 4, number of output channels; power of two, 2..8
- SEL_W, $clog2(N_OUT), destination index width (derived, not overridden)

Ports:
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  reset, asynchronous and active-low
- in_valid  input  1  input beat present
- in_ready  output  1  router accepts beat this cycle
- in_data  input  DATA_W  input payload
- in_last  input  1  final beat of packet
- in_dest  input  SEL_W  destination; sampled only on first beat of a packet
- out_valid  output  N_OUT  one-hot; bit d set when output register holds a beat for channel d
- out_ready  input  N_OUT  per-channel ready
- out_data  output  DATA_W  shared payload bus for all channels
- out_last  output  1  last flag of held beat
- busy  output  1  high while a packet is open (state PKT)
- cur_dest  output  SEL_W  locked destination of open packet; holds last value in IDLE
- pkt_cnt  output  16*N_OUT  per-channel completed-packet counters, channel d at bits [16d+15:16d]

## Operation
- States: IDLE (no packet open), PKT (packet open, destination locked).
- IDLE: accepted beat (in_valid & in_ready) latches in_dest into cur_dest. If in_last=1 (single-beat packet) stay IDLE, else go PKT.
- PKT: in_dest ignored; every accepted beat uses cur_dest. Accepted beat with in_last=1 returns to IDLE.
- Output register (data, last, dest, full flag): loaded on every accepted beat with data, last and effective destination (in_dest in IDLE, cur_dest in PKT).
- out_valid = full ? (1 << reg_dest) : 0. out_data/out_last reflect register contents; out_data holds stale value when empty.
- Beat leaves when full & out_ready[reg_dest]. out_ready bits of other channels are ignored.
- in_ready = !full | out_ready[reg_dest]. Simultaneous leave and accept: register reloads, full stays 1.
- Back-to-back packets to different channels are permitted with no bubble: register carries its own dest, so the last beat of packet A may drain while first beat of packet B loads.
- Reset values: in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0, cur_dest=0, pkt_cnt=0, state IDLE, full=0.
- Reset mid-packet discards the held beat and open packet; no partial-packet recovery.

## Timing
- Latency: beat accepted in cycle t appears on out_valid in cycle t+1.
- Throughput: 1 beat/cycle when target out_ready held high.
- in_ready is combinational from out_ready and register state; no combinational path from in_valid to out_valid.
- Downstream stall: out_valid and out_data stable until out_ready[reg_dest]=1.
- busy rises cycle after first non-last beat accepted; falls cycle after last beat accepted (not when it drains).

## Configuration
- DEMUX_PKTCNT_EN defined: per-channel 16-bit counter increments on each beat leaving with out_last=1 for that channel; wraps 0xFFFF -> 0x0000; cleared only by reset.
- DEMUX_PKTCNT_EN undefined: counter logic absent; pkt_cnt port present and tied to all zeros.

## Test plan
- Reset: assert rst_n=0 mid-packet with register full -> all outputs return to reset values asynchronously; after release, busy=0, in_ready=1.
- Single packet, N_OUT=4: 3 beats 0x11,0x22,0x33 (last on 0x33), in_dest=2 on first beat, in_dest=0 on later beats -> all three on channel 2 (out_valid=4'b0100), one per cycle, busy high for 2 cycles.
- Stall: channel 1 out_ready=0 for 5 cycles with beat 0xA5 held -> out_valid=4'b0010, out_data=0xA5 stable, in_ready=0; release -> beat drains, next beat accepted same cycle.
- Back-to-back: single-beat packet 0x01 to dest 3 then 0x02 to dest 0 on consecutive cycles, all ready -> out_valid 4'b1000 then 4'b0001 on consecutive cycles, no bubble.
- Wrong-channel ready: beat for dest 0, only out_ready[3]=1 -> beat held, in_ready=0.
- With DEMUX_PKTCNT_EN: send 5 packets to dest 1 and 2 to dest 3 -> pkt_cnt channel 1 = 5, channel 3 = 2, others 0; preload-free wrap check by 65536 single-beat packets to dest 0 -> count 0.
